// File: rtl/hotspot_pos_ctrl_if.sv
// -----------------------------------------------------------------------------
// hotspot_pos_ctrl_if
// Position-sample channel from the localization engine to the hotspot
// position controller. A sample transfers on any rising clk_pix edge where
// pos_valid and pos_ready are both high.
//
// Signals
//   pos_valid  engine -> ctrl   sample on pos_x/pos_y is valid
//   pos_ready  ctrl -> engine   controller accepts the sample this cycle
//   pos_x      engine -> ctrl   signed 32-bit X coordinate in pixels
//   pos_y      engine -> ctrl   signed 32-bit Y coordinate in pixels
//
// Modports
//   master  localization engine side
//   slave   hotspot_pos_ctrl side
// -----------------------------------------------------------------------------
interface hotspot_pos_ctrl_if;
   logic               pos_valid;
   logic               pos_ready;
   logic signed [31:0] pos_x;
   logic signed [31:0] pos_y;

   modport master (
      output pos_valid,
      output pos_x,
      output pos_y,
      input  pos_ready
   );

   modport slave (
      input  pos_valid,
      input  pos_x,
      input  pos_y,
      output pos_ready
   );
endinterface

// File: rtl/hotspot_pos_ctrl.sv
// -----------------------------------------------------------------------------
// hotspot_pos_ctrl
// Accepts position samples from the localization engine, clamps them to the
// display area and commits them to the overlay once per frame, on the cycle
// after the frame tick derived from vs_in. The overlay is hidden after
// TIMEOUT_FRAMES consecutive frames without a new sample.
//
// Parameters
//   H_RES           horizontal clamp limit for the hotspot centre
//   V_RES           vertical clamp limit for the hotspot centre
//   TIMEOUT_FRAMES  empty frames before hiding the hotspot (1..255)
//
// Ports
//   clk_pix   pixel clock, rising edge
//   rst_n     asynchronous active-low reset
//   pos       slave side of hotspot_pos_ctrl_if (valid/ready, x, y)
//   vs_in     active-high vertical sync
//   hs_x      committed hotspot centre X
//   hs_y      committed hotspot centre Y
//   hs_ena    one-cycle strobe in the cycle hs_x/hs_y change
//   ovl_show  overlay enable
//
// Build option
//   HOTSPOT_SMOOTH_EN  when defined, commits made while already showing are
//                      low-pass filtered: hs = (3*hs + new + 2) >> 2.
//                      Loads out of IDLE are always direct.
// -----------------------------------------------------------------------------
module hotspot_pos_ctrl #(
   parameter int H_RES          = 480,
   parameter int V_RES          = 272,
   parameter int TIMEOUT_FRAMES = 30
) (
   input  logic                clk_pix,
   input  logic                rst_n,
   hotspot_pos_ctrl_if.slave   pos,
   input  logic                vs_in,
   output logic [15:0]         hs_x,
   output logic [15:0]         hs_y,
   output logic                hs_ena,
   output logic                ovl_show
);

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

   localparam logic signed [31:0] H_LIM       = 32'(H_RES);
   localparam logic signed [31:0] V_LIM       = 32'(V_RES);
   localparam logic [7:0]         TIMEOUT_CNT = 8'(TIMEOUT_FRAMES);

   state_t      state;
   state_t      state_next;
   logic        vs_q;
   logic        frame_tick;
   logic        ready_q;
   logic        handshake;
   logic        pending_flag;
   logic [15:0] pend_x;
   logic [15:0] pend_y;
   logic [7:0]  miss_cnt;
   logic [7:0]  miss_next;
   logic [7:0]  miss_inc;
   logic [15:0] hs_x_next;
   logic [15:0] hs_y_next;
   logic        commit;

   // Negative coordinates pin to 0, anything beyond the limit pins to it.
   function automatic logic [15:0] clamp_coord(input logic signed [31:0] v,
                                               input logic signed [31:0] lim);
      logic [15:0] r;
      if (v < 0)
         r = 16'd0;
      else if (v > lim)
         r = lim[15:0];
      else
         r = v[15:0];
      return r;
   endfunction

   assign pos.pos_ready = ready_q;
   assign handshake     = pos.pos_valid & ready_q;
   assign miss_inc      = miss_cnt + 8'd1;

`ifdef HOTSPOT_SMOOTH_EN
   logic [15:0] smooth_x;
   logic [15:0] smooth_y;

   // 18 bits hold 3*65535 + 65535 + 2 without overflow.
   assign smooth_x = 16'(({2'b00, hs_x} * 18'd3 + {2'b00, pend_x} + 18'd2) >> 2);
   assign smooth_y = 16'(({2'b00, hs_y} * 18'd3 + {2'b00, pend_y} + 18'd2) >> 2);
`endif

   // Frame tick is the registered rising edge of vs_in; ready stays low only
   // while reset is asserted.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         vs_q       <= 1'b0;
         frame_tick <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         vs_q       <= vs_in;
         frame_tick <= vs_in & ~vs_q;
         ready_q    <= 1'b1;
      end
   end

   // Single pending slot: latest sample wins, and a handshake arriving in the
   // commit cycle keeps the flag set because the commit consumed the old one.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         pend_x       <= 16'd0;
         pend_y       <= 16'd0;
         pending_flag <= 1'b0;
      end else if (handshake) begin
         pend_x       <= clamp_coord(pos.pos_x, H_LIM);
         pend_y       <= clamp_coord(pos.pos_y, V_LIM);
         pending_flag <= 1'b1;
      end else if (commit) begin
         pending_flag <= 1'b0;
      end
   end

   // Next-state logic: commits and miss counting only happen on frame_tick.
   always_comb begin
      state_next = state;
      hs_x_next  = hs_x;
      hs_y_next  = hs_y;
      miss_next  = miss_cnt;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (frame_tick && pending_flag) begin
               commit     = 1'b1;
               hs_x_next  = pend_x;
               hs_y_next  = pend_y;
               miss_next  = 8'd0;
               state_next = SHOW;
            end
         end
         SHOW: begin
            if (frame_tick) begin
               if (pending_flag) begin
                  commit    = 1'b1;
`ifdef HOTSPOT_SMOOTH_EN
                  hs_x_next = smooth_x;
                  hs_y_next = smooth_y;
`else
                  hs_x_next = pend_x;
                  hs_y_next = pend_y;
`endif
                  miss_next = 8'd0;
               end else if (miss_inc == TIMEOUT_CNT) begin
                  miss_next  = 8'd0;
                  state_next = IDLE;
               end else begin
                  miss_next  = miss_inc;
               end
            end
         end
      endcase
   end

   // Output and state registers; ovl_show follows the state being entered.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hs_x     <= 16'd0;
         hs_y     <= 16'd0;
         miss_cnt <= 8'd0;
         hs_ena   <= 1'b0;
         ovl_show <= 1'b0;
      end else begin
         state    <= state_next;
         hs_x     <= hs_x_next;
         hs_y     <= hs_y_next;
         miss_cnt <= miss_next;
         hs_ena   <= commit;
         ovl_show <= (state_next == SHOW);
      end
   end

endmodule

// File: tb/tb_hotspot_pos_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hotspot_pos_ctrl
// Self-checking bench for hotspot_pos_ctrl. A frame-level reference model
// tracks the latest accepted sample, the committed position, the overlay
// visibility and the run of empty frames. Directed scenarios are followed by
// randomized frames with random sample counts and out-of-range coordinates.
// Honours HOTSPOT_SMOOTH_EN when defined for the whole build.
// -----------------------------------------------------------------------------
module tb_hotspot_pos_ctrl;

   localparam int H_RES   = 480;
   localparam int V_RES   = 272;
   localparam int TIMEOUT = 30;
`ifdef HOTSPOT_SMOOTH_EN
   localparam bit SMOOTH = 1'b1;
`else
   localparam bit SMOOTH = 1'b0;
`endif

   logic        clk_pix = 1'b0;
   logic        rst_n   = 1'b0;
   logic        vs_in   = 1'b0;
   logic [15:0] hs_x;
   logic [15:0] hs_y;
   logic        hs_ena;
   logic        ovl_show;

   hotspot_pos_ctrl_if pos_bus ();

   hotspot_pos_ctrl #(
      .H_RES          (H_RES),
      .V_RES          (V_RES),
      .TIMEOUT_FRAMES (TIMEOUT)
   ) dut (
      .clk_pix  (clk_pix),
      .rst_n    (rst_n),
      .pos      (pos_bus.slave),
      .vs_in    (vs_in),
      .hs_x     (hs_x),
      .hs_y     (hs_y),
      .hs_ena   (hs_ena),
      .ovl_show (ovl_show)
   );

   always #5 clk_pix = ~clk_pix;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_x, m_y;
   int m_px, m_py;
   bit m_pend;
   bit m_show;
   int m_miss;

   task automatic check_output(input string tag, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   function automatic int clamp_ref(input int v, input int lim);
      if (v < 0)   return 0;
      if (v > lim) return lim;
      return v;
   endfunction

   function automatic int rand_coord(input int lim);
      if ($urandom_range(0, 7) == 0)
         return int'($urandom());
      return int'($urandom_range(0, lim + 220)) - 100;
   endfunction

   task automatic model_reset();
      m_x = 0; m_y = 0; m_px = 0; m_py = 0;
      m_pend = 1'b0; m_show = 1'b0; m_miss = 0;
   endtask

   task automatic model_accept(input int x, input int y);
      m_px   = clamp_ref(x, H_RES);
      m_py   = clamp_ref(y, V_RES);
      m_pend = 1'b1;
   endtask

   // One frame boundary: commit the latest sample or count an empty frame.
   task automatic model_tick(output bit ena);
      ena = 1'b0;
      if (m_pend) begin
         if (m_show && SMOOTH) begin
            m_x = (3 * m_x + m_px + 2) / 4;
            m_y = (3 * m_y + m_py + 2) / 4;
         end else begin
            m_x = m_px;
            m_y = m_py;
         end
         m_show = 1'b1;
         m_miss = 0;
         m_pend = 1'b0;
         ena    = 1'b1;
      end else if (m_show) begin
         m_miss++;
         if (m_miss == TIMEOUT) begin
            m_show = 1'b0;
            m_miss = 0;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk_pix);
      rst_n = 1'b0;
      #1;
      check_output("rst_hs_x", hs_x, 0);
      check_output("rst_hs_y", hs_y, 0);
      check_output("rst_hs_ena", hs_ena, 0);
      check_output("rst_ovl_show", ovl_show, 0);
      check_output("rst_pos_ready", pos_bus.pos_ready, 0);
      model_reset();
      repeat (2) @(negedge clk_pix);
      rst_n = 1'b1;
      @(negedge clk_pix);
      check_output("ready_after_rst", pos_bus.pos_ready, 1);
   endtask

   task automatic apply_stimulus(input int x, input int y);
      @(negedge clk_pix);
      pos_bus.pos_valid = 1'b1;
      pos_bus.pos_x     = x;
      pos_bus.pos_y     = y;
      check_output("pos_ready", pos_bus.pos_ready, 1);
      @(negedge clk_pix);
      pos_bus.pos_valid = 1'b0;
      model_accept(x, y);
   endtask

   // Pulse vs_in for one cycle, optionally presenting a sample in the cycle
   // the frame tick is high, then check strobe timing and committed outputs.
   task automatic apply_frame(input bit coin, input int cx, input int cy);
      int old_x, old_y, ena_cnt, ena_at;
      bit exp_ena;
      old_x = m_x;
      old_y = m_y;
      @(negedge clk_pix);
      vs_in = 1'b1;
      @(negedge clk_pix);
      vs_in = 1'b0;
      if (coin) begin
         pos_bus.pos_valid = 1'b1;
         pos_bus.pos_x     = cx;
         pos_bus.pos_y     = cy;
      end
      model_tick(exp_ena);
      if (coin) model_accept(cx, cy);
      ena_cnt = 0;
      ena_at  = -1;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) pos_bus.pos_valid = 1'b0;
         if (hs_ena) begin
            ena_cnt++;
            if (ena_at < 0) ena_at = i;
         end
         if (i == 0) begin
            check_output("hs_x_not_early", hs_x, old_x);
            check_output("hs_y_not_early", hs_y, old_y);
         end
         @(negedge clk_pix);
      end
      check_output("hs_ena_count", ena_cnt, exp_ena ? 1 : 0);
      if (exp_ena) check_output("hs_ena_cycle", ena_at, 1);
      check_output("hs_x", hs_x, m_x);
      check_output("hs_y", hs_y, m_y);
      check_output("ovl_show", ovl_show, m_show ? 1 : 0);
   endtask

   initial begin
      pos_bus.pos_valid = 1'b0;
      pos_bus.pos_x     = 0;
      pos_bus.pos_y     = 0;
      model_reset();

      $display("[TB] reset");
      apply_reset();

      $display("[TB] empty frame in IDLE");
      apply_frame(1'b0, 0, 0);

      $display("[TB] first sample");
      apply_stimulus(100, 50);
      apply_frame(1'b0, 0, 0);

      $display("[TB] clamping");
      apply_stimulus(-20, 400);
      apply_frame(1'b0, 0, 0);
      apply_stimulus(600, 10);
      apply_frame(1'b0, 0, 0);

      $display("[TB] latest sample wins and smoothing step");
      apply_stimulus(5, 5);
      apply_stimulus(100, 100);
      apply_frame(1'b0, 0, 0);
      apply_stimulus(200, 100);
      apply_frame(1'b0, 0, 0);

      $display("[TB] timeout");
      for (int f = 0; f < TIMEOUT; f++) apply_frame(1'b0, 0, 0);
      apply_frame(1'b0, 0, 0);
      apply_stimulus(300, 200);
      apply_frame(1'b0, 0, 0);

      $display("[TB] sample coincident with frame tick");
      apply_stimulus(10, 7);
      apply_frame(1'b1, 20, 9);
      apply_frame(1'b0, 0, 0);

      $display("[TB] randomized frames");
      for (int f = 0; f < 60; f++) begin
         int n;
         n = int'($urandom_range(0, 3));
         if (n == 3) n = 0;
         for (int s = 0; s < n; s++) apply_stimulus(rand_coord(H_RES), rand_coord(V_RES));
         if ($urandom_range(0, 4) == 0)
            apply_frame(1'b1, rand_coord(H_RES), rand_coord(V_RES));
         else
            apply_frame(1'b0, 0, 0);
      end

      $display("[TB] reset while a sample is pending in SHOW");
      apply_stimulus(50, 60);
      apply_frame(1'b0, 0, 0);
      apply_stimulus(70, 80);
      @(negedge clk_pix);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midrst_hs_x", hs_x, 0);
      check_output("midrst_hs_y", hs_y, 0);
      check_output("midrst_hs_ena", hs_ena, 0);
      check_output("midrst_ovl_show", ovl_show, 0);
      check_output("midrst_pos_ready", pos_bus.pos_ready, 0);
      model_reset();
      @(negedge clk_pix);
      rst_n = 1'b1;
      @(negedge clk_pix);
      apply_frame(1'b0, 0, 0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
